packed_array_sched: RTL and testbench

//  Sequencer and arbiter for a shared 4 x 8-bit packed-array register file.
//  - Two requesters (A, B) each present a 32-bit word plus a 4-bit slice override.
//  - A round-robin arbiter grants one requester; an FSM writes the elements one per

---
 rtl/packed_array_sched.sv | 127 ++++++++++++
 tb/tb_packed_array_sched.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/packed_array_sched.sv
// Round-robin sequencer for a shared 4 x 8-bit packed register file: grants one of two
// requesters, writes the elements one per cycle, then stores byte0 + byte1 in element3.
module packed_array_sched #(
  parameter int unsigned ELEM_W   = 8,
  parameter bit          WRAP_SUM = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              req_a,
  input  logic [31:0]       data_a,
  input  logic [3:0]        slice_a,
  output logic              gnt_a,
  input  logic              req_b,
  input  logic [31:0]       data_b,
  input  logic [3:0]        slice_b,
  output logic              gnt_b,
  output logic              busy,
  output logic              done,
  output logic [ELEM_W-1:0] out_elem0,
  output logic [ELEM_W-1:0] out_elem1,
  output logic [ELEM_W-1:0] out_sum
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad0,
    StLoad1,
    StLoad2,
    StSum,
    StDone
  } state_e;

  state_e                 r_state;
  logic                   r_rr_b;     // 1: B wins the next tie
  logic [23:0]            r_data;
  logic [3:0]             r_slice;
  logic [3:0][ELEM_W-1:0] r_arr;
  logic                   r_busy;
  logic                   r_done;

  logic                   w_grant_ok;
  logic                   w_pick_b;
  logic                   w_gnt_a;
  logic                   w_gnt_b;
  logic [8:0]             w_sum9;
  logic [7:0]             w_sum;
  logic                   w_unused_bits;

  // Arbitration is the only combinational path from the requests to the grants.
  assign w_grant_ok = (r_state == StIdle) && enable && !rst;
  assign w_pick_b   = req_b && (!req_a || r_rr_b);
  assign w_gnt_a    = w_grant_ok && req_a && !w_pick_b;
  assign w_gnt_b    = w_grant_ok && w_pick_b;

  // Sum uses the shadowed byte0, not element0 with the slice override applied.
  assign w_sum9 = {1'b0, r_data[7:0]} + {1'b0, r_data[15:8]};
  assign w_sum  = (WRAP_SUM || !w_sum9[8]) ? w_sum9[7:0] : 8'hFF;

  assign w_unused_bits = ^{data_a[31:24], data_b[31:24], r_arr[2]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_rr_b  <= 1'b0;
      r_data  <= '0;
      r_slice <= '0;
      r_arr   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (!enable) begin
      r_state <= StIdle;
      r_arr   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_done <= 1'b0;
          if (w_gnt_a || w_gnt_b) begin
            r_data  <= w_gnt_b ? data_b[23:0] : data_a[23:0];
            r_slice <= w_gnt_b ? slice_b : slice_a;
            r_rr_b  <= w_gnt_a;
            r_busy  <= 1'b1;
            r_state <= StLoad0;
          end
        end
        StLoad0: begin
          r_arr[0] <= {r_data[7:4], r_slice};
          r_state  <= StLoad1;
        end
        StLoad1: begin
          r_arr[1] <= r_data[15:8];
          r_state  <= StLoad2;
        end
        StLoad2: begin
          r_arr[2] <= r_data[23:16];
          r_state  <= StSum;
        end
        StSum: begin
          r_arr[3] <= w_sum;
          r_done   <= 1'b1;
          r_state  <= StDone;
        end
        StDone: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign gnt_a     = w_gnt_a;
  assign gnt_b     = w_gnt_b;
  assign busy      = r_busy;
  assign done      = r_done;
  assign out_elem0 = r_arr[0];
  assign out_elem1 = r_arr[1];
  assign out_sum   = r_arr[3];

endmodule

// File: tb/tb_packed_array_sched.sv
// Scoreboard bench for packed_array_sched: a wrapping and a saturating instance share stimulus.
module tb_packed_array_sched;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        req_a;
  logic [31:0] data_a;
  logic [3:0]  slice_a;
  logic        req_b;
  logic [31:0] data_b;
  logic [3:0]  slice_b;

  logic       gnt_a, gnt_b, busy, done;
  logic [7:0] out_elem0, out_elem1, out_sum;
  logic       gnt_a_s, gnt_b_s, busy_s, done_s;
  logic [7:0] elem0_s, elem1_s, sum_s;

  typedef struct {
    logic [7:0] e0;
    logic [7:0] e1;
    logic [7:0] sw;
    logic [7:0] ss;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   rr_m   = 1'b0;

  packed_array_sched #(.ELEM_W(8), .WRAP_SUM(1'b1)) u_dut (
    .clk(clk), .rst(rst), .enable(enable),
    .req_a(req_a), .data_a(data_a), .slice_a(slice_a), .gnt_a(gnt_a),
    .req_b(req_b), .data_b(data_b), .slice_b(slice_b), .gnt_b(gnt_b),
    .busy(busy), .done(done),
    .out_elem0(out_elem0), .out_elem1(out_elem1), .out_sum(out_sum)
  );

  packed_array_sched #(.ELEM_W(8), .WRAP_SUM(1'b0)) u_dut_sat (
    .clk(clk), .rst(rst), .enable(enable),
    .req_a(req_a), .data_a(data_a), .slice_a(slice_a), .gnt_a(gnt_a_s),
    .req_b(req_b), .data_b(data_b), .slice_b(slice_b), .gnt_b(gnt_b_s),
    .busy(busy_s), .done(done_s),
    .out_elem0(elem0_s), .out_elem1(elem1_s), .out_sum(sum_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] d, input logic [3:0] s);
    exp_t       e;
    logic [8:0] s9;
    s9   = {1'b0, d[7:0]} + {1'b0, d[15:8]};
    e.e0 = {d[7:4], s};
    e.e1 = d[15:8];
    e.sw = s9[7:0];
    e.ss = s9[8] ? 8'hFF : s9[7:0];
    return e;
  endfunction

  always @(negedge clk) begin
    if (done || done_s) begin
      check_val("done_pair", done_s, done);
      if (exp_q.size() == 0) begin
        check_val("unexpected_done", done, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_val("elem0", out_elem0, e.e0);
        check_val("elem1", out_elem1, e.e1);
        check_val("sum_wrap", out_sum, e.sw);
        check_val("sum_sat", sum_s, e.ss);
        check_val("elem0_sat", elem0_s, e.e0);
      end
    end
  end

  // Single-requester transaction; enable is raised together with the request.
  task automatic txn(input bit side_b, input logic [31:0] d, input logic [3:0] s);
    @(posedge clk); #1;
    enable = 1'b1;
    if (side_b) begin
      req_b = 1'b1; data_b = d; slice_b = s;
    end else begin
      req_a = 1'b1; data_a = d; slice_a = s;
    end
    exp_q.push_back(model(d, s));
    @(negedge clk);
    check_val("txn_gnt_a", gnt_a, !side_b);
    check_val("txn_gnt_b", gnt_b, side_b);
    check_val("txn_busy_idle", busy, 0);
    @(posedge clk); #1;
    req_a = 1'b0;
    req_b = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check_val("txn_busy_run", busy, 1);
      check_val("txn_done_lat", done, (k == 5));
    end
    @(negedge clk);
    check_val("txn_busy_end", busy, 0);
    rr_m = !side_b;
  endtask

  initial begin
    bit  got;
    time t_last;
    rst = 1'b1; enable = 1'b1;
    req_a = 1'b1; data_a = 32'h1234_5678; slice_a = 4'h5;
    req_b = 1'b0; data_b = '0; slice_b = '0;

    // Reset: requests are ignored and every output is zero.
    @(negedge clk);
    check_val("rst_gnt_a", gnt_a, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_outs", {out_elem0, out_elem1, out_sum}, 0);
    @(posedge clk); #1 req_a = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_val("post_rst_outs", {out_elem0, out_elem1, out_sum}, 0);
    check_val("post_rst_busy", busy, 0);

    txn(1'b0, 32'hAA33_2211, 4'hF);
    txn(1'b0, 32'h0000_20F0, 4'h3);
    txn(1'b1, 32'h0000_01FF, 4'hC);
    txn(1'b1, 32'h1234_7F80, 4'h0);

    // Both requesters held from reset: A, B, A at six-cycle spacing.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    rr_m = 1'b0;
    req_a = 1'b1; data_a = 32'h0011_0A05; slice_a = 4'h1;
    req_b = 1'b1; data_b = 32'h0099_9060; slice_b = 4'h2;
    t_last = 0;
    for (int g = 0; g < 3; g++) begin
      got = 1'b0;
      for (int w = 0; w < 10 && !got; w++) begin
        @(negedge clk);
        if (gnt_a || gnt_b) got = 1'b1;
      end
      if (!got) begin
        check_val("rr_gnt_timeout", gnt_a | gnt_b, 1);
        break;
      end
      check_val("rr_gnt_b", gnt_b, rr_m);
      check_val("rr_gnt_a", gnt_a, !rr_m);
      exp_q.push_back(rr_m ? model(data_b, slice_b) : model(data_a, slice_a));
      if (g > 0) check_val("rr_spacing", ($time - t_last) / 10, 6);
      t_last = $time;
      rr_m = !rr_m;
      @(posedge clk); #1;
      if (g == 0) begin
        data_a = 32'h0055_4433; slice_a = 4'h7;
      end
    end
    req_a = 1'b0;
    req_b = 1'b0;
    repeat (8) @(negedge clk);

    // Enable dropped in LOAD1: abort, clear, and no grant while enable stays low.
    @(posedge clk); #1;
    req_a = 1'b1; data_a = 32'h0044_5566; slice_a = 4'h9;
    @(negedge clk);
    check_val("ab_gnt_a", gnt_a, 1);
    rr_m = 1'b1;
    @(posedge clk); #1 req_a = 1'b0;
    @(posedge clk); #1 enable = 1'b0;
    @(negedge clk);
    check_val("ab_partial_elem0", out_elem0, 8'h69);
    check_val("ab_busy_load1", busy, 1);
    @(negedge clk);
    check_val("ab_busy", busy, 0);
    check_val("ab_outs", {out_elem0, out_elem1, out_sum}, 0);
    @(posedge clk); #1;
    req_b = 1'b1; data_b = 32'h0000_0302; slice_b = 4'h4;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val("ab_no_gnt_b", gnt_b, 0);
    end
    txn(1'b1, 32'h0000_0302, 4'h4);

    // Reset during SUM: immediate clear and no done.
    @(posedge clk); #1;
    req_a = 1'b1; data_a = 32'h0000_4321; slice_a = 4'hE;
    @(negedge clk);
    check_val("rs_gnt_a", gnt_a, 1);
    @(posedge clk); #1 req_a = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check_val("rs_outs_now", {out_elem0, out_elem1, out_sum}, 0);
    check_val("rs_busy_now", busy, 0);
    @(negedge clk);
    check_val("rs_done", done, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (6) @(negedge clk);
    txn(1'b1, 32'h0000_8877, 4'h6);

    repeat (3) @(negedge clk);
    check_val("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
